// File: rtl/time_field_editor.sv
// time_field_editor: cursor-driven BCD field editor with per-digit limits, commit/cancel and auto-repeat
module time_field_editor #(
  parameter int NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] MAX_VEC = 16'h5959,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    edit_en,
  input  logic                    cancel,
  input  logic                    btn_u,
  input  logic                    btn_d,
  input  logic                    btn_l,
  input  logic                    btn_r,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [4*NUM_DIGITS-1:0] edit_value,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blink,
  output logic                    editing,
  output logic                    done,
  output logic                    aborted
);
  localparam int W = 4*NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX+1);
  localparam int BW = $clog2(BLINK_HALF+1);
  localparam logic [CW-1:0] TOP = CW'(NUM_DIGITS-1);
  typedef enum logic {IDLE, EDIT} state_t;
  state_t state, state_n;
  logic edit_q, u_q, d_q, l_q, r_q;
  logic u_rep, d_rep, u_fire, d_fire;
  logic [RW-1:0] u_cnt, d_cnt;
  logic [BW-1:0] b_cnt;
  logic blink_q;
  logic [CW-1:0] cursor, cur_n;
  logic [3:0] dig, lim, dig_n;
  logic [W-1:0] ev_n;
  logic edit_rise, ev_u, ev_d, ev_l, ev_r;
  assign edit_rise = edit_en & ~edit_q;
  assign u_fire = btn_u & u_q & (u_cnt == (u_rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
  assign d_fire = btn_d & d_q & (d_cnt == (d_rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
  assign ev_u = (btn_u & ~u_q) | u_fire;
  assign ev_d = (btn_d & ~d_q) | d_fire;
  assign ev_l = btn_l & ~l_q;
  assign ev_r = btn_r & ~r_q;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? (edit_rise ? EDIT : IDLE) : ((cancel | ~edit_en) ? IDLE : EDIT);
  always_comb begin
    editing = (state == EDIT);
    digit_en = editing ? (NUM_DIGITS'(1) << cursor) : '1;
    blink = blink_q & editing;
  end
  always_ff @(posedge clk)
    if (reset) {edit_q, u_q, d_q, l_q, r_q} <= '0;
    else {edit_q, u_q, d_q, l_q, r_q} <= {edit_en, btn_u, btn_d, btn_l, btn_r};
  // Repeat counters restart at each edge; the first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
  always_ff @(posedge clk) begin
    if (reset || state != EDIT || !btn_u) {u_rep, u_cnt} <= '0;
    else if (!u_q) {u_rep, u_cnt} <= {1'b0, RW'(1)};
    else if (u_fire) {u_rep, u_cnt} <= {1'b1, RW'(1)};
    else u_cnt <= u_cnt + RW'(1);
    if (reset || state != EDIT || !btn_d) {d_rep, d_cnt} <= '0;
    else if (!d_q) {d_rep, d_cnt} <= {1'b0, RW'(1)};
    else if (d_fire) {d_rep, d_cnt} <= {1'b1, RW'(1)};
    else d_cnt <= d_cnt + RW'(1);
  end
  always_ff @(posedge clk)
    if (reset || state != EDIT) {blink_q, b_cnt} <= '0;
    else if (b_cnt == BW'(BLINK_HALF-1)) {blink_q, b_cnt} <= {~blink_q, BW'(0)};
    else b_cnt <= b_cnt + BW'(1);
  // Out-of-range digits (from load) snap to 0 on up and to the limit on down.
  always_comb begin
    dig = edit_value[{cursor, 2'b00} +: 4];
    lim = MAX_VEC[{cursor, 2'b00} +: 4];
    dig_n = ev_d ? ((dig == 4'd0 || dig > lim) ? lim : dig - 4'd1) : ((dig >= lim) ? 4'd0 : dig + 4'd1);
    ev_n = edit_value;
    ev_n[{cursor, 2'b00} +: 4] = dig_n;
    cur_n = ev_l ? ((cursor == TOP) ? '0 : cursor + CW'(1)) : ((cursor == '0) ? TOP : cursor - CW'(1));
  end
  always_ff @(posedge clk)
    if (reset) begin
      value <= '0;
      edit_value <= '0;
      cursor <= TOP;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE) begin
        if (edit_rise) begin
          edit_value <= value;
          cursor <= TOP;
        end else if (load_valid) value <= load_data;
      end else if (cancel) aborted <= 1'b1;
      else if (!edit_en) begin
        value <= edit_value;
        done <= 1'b1;
      end else if (ev_d | ev_u) edit_value <= ev_n;
      else if (ev_l | ev_r) cursor <= cur_n;
    end
endmodule
